mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port backing data memory between the instruction-fetch refill port (port 0)
//  and the data-cache refill/writeback port (port 1). Sits between both cache controllers and
//  the memory, one clock domain. Grants one requester at a time and runs a fixed-length word
//  burst for it. Returns per-beat read data and a done pulse to the granted port.
// PARAMETERS
//  ADDR_W    32  byte-address width
//  DATA_W    32  word width; beat address stride is DATA_W/8 bytes
//  BURST_LEN 4   words per transaction (cache line); power of two, 1..16
// PORTS
//  clk          in   1          rising-edge clock
//  rstn         in   1          asynchronous active-low reset
//  p_req        in   2          per-port request; held high until that port's p_done
//  p_we         in   2          per-port write (1) / read (0); stable while p_req high
//  p_addr0      in   ADDR_W     port 0 line base address (line-aligned)
//  p_addr1      in   ADDR_W     port 1 line base address (line-aligned)
//  p_wdata1     in   DATA_W     port 1 write beat data (port 0 is read-only; p_we[0] ignored)
//  p_grant      out  2          one-hot owner of the memory, 0 when idle
//  p_beat       out  2          one-hot: read-data beat valid, or write beat consumed
//  p_rdata      out  DATA_W     read beat data, shared by both ports, qualified by p_beat
//  p_done       out  2          one-cycle pulse after the last beat of the owner's burst
//  mem_req      out  1          memory access strobe, held until mem_ack
//  mem_we       out  1          memory write enable
//  mem_addr     out  ADDR_W     memory byte address
//  mem_wdata    out  DATA_W     memory write data
//  mem_rdata    in   DATA_W     memory read data, valid with mem_ack
//  mem_ack      in   1          memory beat complete, one-cycle pulse
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; beat counter 0; round-robin pointer = port 0 preferred.
//  FSM IDLE -> XFER -> DONE -> IDLE.
//  IDLE: if any p_req, choose winner, latch base address and we, set p_grant next cycle, go XFER.
//   Both requesting: winner = port indicated by rr pointer; pointer flips to the loser after
//   each grant. Single request: that port wins immediately, pointer still updates to other port.
//  XFER: mem_req=1, mem_addr = base + beat*(DATA_W/8), mem_we = latched we, mem_wdata = p_wdata1.
//   On mem_ack: p_beat[owner]=1 that cycle (combinational from mem_ack); read -> p_rdata = mem_rdata;
//   write -> requester presents next word on following cycle. Beat counter increments.
//   mem_req stays high across beats (new address the cycle after ack). Last ack -> DONE.
//  DONE: mem_req=0, p_done[owner]=1 for exactly one cycle, p_grant cleared next cycle, go IDLE.
//  Minimum gap: one IDLE cycle between bursts; back-to-back latency from p_req to first mem_req = 1.
//  Counter wraps to 0 at BURST_LEN; beat address never crosses the line (no carry past line offset).
//  Owner dropping p_req mid-burst: ignored, burst completes; p_done still issued.
//  mem_ack while not in XFER: ignored. p_req changes of non-owner: ignored until IDLE.
//  rstn low mid-burst: immediate return to reset values; burst abandoned, no p_done.
// CONFIGURATION
//  MEM_ARB_DPRIO_EN defined: port 1 (data) always wins simultaneous requests; rr pointer unused.
//  Not defined: round-robin as above. Single-request behaviour identical in both builds.
// TESTING
//  Port 0 read @0x100, mem_ack every 2nd cycle -> mem_addr 0x100,0x104,0x108,0x10C; 4 p_beat[0];
//   p_done[0] one cycle after 4th ack.
//  Port 1 write @0x40, wdata 11,22,33,44 -> memory words 0x40..0x4C = 11,22,33,44; p_done[1].
//  Both req at same cycle after reset, held continuously -> grants alternate 0,1,0,1
//   (MEM_ARB_DPRIO_EN: 1,1,1 while p_req[1] stays high).
//  rstn low during beat 2 of port 1 burst -> outputs 0 within same cycle, no p_done; new request
//   after release starts at beat 0.
//  Spurious mem_ack in IDLE with no req -> no p_beat, no state change.
//  Owner drops p_req after beat 1 -> remaining beats run, p_done pulses, then other port granted.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: the two cache refill ports on one side,
// the single-port backing memory on the other.
// master: the arbiter's view. slave: the requesters' and memory's view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]        p_req;
  logic [1:0]        p_we;
  logic [ADDR_W-1:0] p_addr0;
  logic [ADDR_W-1:0] p_addr1;
  logic [DATA_W-1:0] p_wdata1;
  logic [1:0]        p_grant;
  logic [1:0]        p_beat;
  logic [DATA_W-1:0] p_rdata;
  logic [1:0]        p_done;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  p_req, p_we, p_addr0, p_addr1, p_wdata1, mem_rdata, mem_ack,
    output p_grant, p_beat, p_rdata, p_done, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output p_req, p_we, p_addr0, p_addr1, p_wdata1, mem_rdata, mem_ack,
    input  p_grant, p_beat, p_rdata, p_done, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction
// refill port (0, read-only) and the data refill/writeback port (1).
// Each grant runs a BURST_LEN-word burst at the line base address, then
// pulses p_done for the owner and returns to IDLE.
// Optional build macro MEM_ARB_DPRIO_EN: port 1 wins simultaneous requests
// instead of the default round-robin choice.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4
) (
  input  logic               clk,
  input  logic               rstn,
  mem_port_arbiter_if.master bus
);

  localparam int BYTES   = DATA_W / 8;
  localparam int OFF_LSB = $clog2(BYTES);
  localparam int CNT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BURST_LEN * BYTES - 1);
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;   // 0 = port 0, 1 = port 1
  logic              we_q, we_d;
  logic              rr_q, rr_d;         // port preferred on a tie
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  beat_q, beat_d;

  logic              win;
  logic [1:0]        owner_oh;
  logic [ADDR_W-1:0] beat_off;
  logic [ADDR_W-1:0] beat_addr;

  assign owner_oh = owner_q ? 2'b10 : 2'b01;

  // Beat address: offset added inside the line only, so it can never carry
  // into the line-base bits.
  assign beat_off  = ADDR_W'(beat_q) << OFF_LSB;
  assign beat_addr = (base_q & ~LINE_MASK) | ((base_q + beat_off) & LINE_MASK);

  // Winner selection among the current requests.
  always_comb begin
    win = bus.p_req[1];
    if (bus.p_req == 2'b11) begin
`ifdef MEM_ARB_DPRIO_EN
      win = 1'b1;
`else
      win = rr_q;
`endif
    end
  end

  // Next-state and output decode for IDLE -> XFER -> DONE -> IDLE.
  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path
    // through the case leaves one unassigned and infers a latch.
    state_d       = state_q;
    owner_d       = owner_q;
    we_d          = we_q;
    rr_d          = rr_q;
    base_d        = base_q;
    beat_d        = beat_q;
    bus.p_grant   = '0;
    bus.p_beat    = '0;
    bus.p_rdata   = '0;
    bus.p_done    = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    unique case (state_q)
      IDLE: begin
        if (|bus.p_req) begin
          state_d = XFER;
          owner_d = win;
          // Port 0 is read-only: its write bit is masked off.
          we_d    = bus.p_we[win] & win;
          base_d  = win ? bus.p_addr1 : bus.p_addr0;
          beat_d  = '0;
          rr_d    = ~win;
        end
      end
      XFER: begin
        bus.p_grant   = owner_oh;
        bus.mem_req   = 1'b1;
        bus.mem_we    = we_q;
        bus.mem_addr  = beat_addr;
        bus.mem_wdata = bus.p_wdata1;
        if (bus.mem_ack) begin
          bus.p_beat = owner_oh;
          if (!we_q) bus.p_rdata = bus.mem_rdata;
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d  = beat_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        bus.p_grant = owner_oh;
        bus.p_done  = owner_oh;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and burst-context registers; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      rr_q    <= 1'b0;
      base_q  <= '0;
      beat_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      rr_q    <= rr_d;
      base_q  <= base_d;
      beat_q  <= beat_d;
    end
  end

endmodule
